// File: rtl/axi_rw_master.sv
// Single-outstanding AXI4 master: turns each held ram_rw request into one
// single-beat AXI4 read (AR/R) or write (AW/W/B) with byte-lane alignment.
module axi_rw_master #(
  parameter int unsigned AXI_ID = 0,
  parameter int unsigned ID_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rw_cen,
  input  logic            rw_wen,
  input  logic [63:0]     rw_addr,
  input  logic [63:0]     rw_wdata,
  input  logic [2:0]      rw_size,
  output logic            rw_ready,
  output logic [63:0]     rw_rdata,
  output logic            rw_err,
  output logic            axi_arvalid,
  input  logic            axi_arready,
  output logic [63:0]     axi_araddr,
  output logic [ID_W-1:0] axi_arid,
  output logic [7:0]      axi_arlen,
  output logic [2:0]      axi_arsize,
  output logic [1:0]      axi_arburst,
  input  logic            axi_rvalid,
  output logic            axi_rready,
  input  logic [63:0]     axi_rdata,
  input  logic [1:0]      axi_rresp,
  input  logic            axi_rlast,
  input  logic [ID_W-1:0] axi_rid,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [63:0]     axi_awaddr,
  output logic [ID_W-1:0] axi_awid,
  output logic [7:0]      axi_awlen,
  output logic [2:0]      axi_awsize,
  output logic [1:0]      axi_awburst,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  output logic [63:0]     axi_wdata,
  output logic [7:0]      axi_wstrb,
  output logic            axi_wlast,
  input  logic            axi_bvalid,
  output logic            axi_bready,
  input  logic [1:0]      axi_bresp,
  input  logic [ID_W-1:0] axi_bid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // With one transaction outstanding the response IDs and RLAST carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{axi_rlast, axi_rid, axi_bid};

  // Sizes above a dword cannot occur on a 64-bit bus, so they collapse to dword.
  function automatic logic [1:0] clamp_size(input logic [2:0] s);
    return s[2] ? 2'd3 : s[1:0];
  endfunction

  function automatic logic [7:0] lane_strb(input logic [1:0] sz, input logic [2:0] sh);
    logic [7:0] base;
    case (sz)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << sh;
  endfunction

  function automatic logic [63:0] read_align(input logic [63:0] d, input logic [2:0] sh,
                                             input logic [1:0] sz);
    logic [63:0] s;
    s = d >> {sh, 3'b000};
    case (sz)
      2'd0:    return {56'd0, s[7:0]};
      2'd1:    return {48'd0, s[15:0]};
      2'd2:    return {32'd0, s[31:0]};
      default: return s;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (rw_cen) begin
          addr_d = rw_addr;
          size_d = clamp_size(rw_size);
          if (rw_wen) begin
            wdata_d   = rw_wdata << {rw_addr[2:0], 3'b000};
            wstrb_d   = lane_strb(clamp_size(rw_size), rw_addr[2:0]);
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_AW_W;
          end else begin
            state_d = S_AR;
          end
        end
      end
      S_AR: begin
        if (axi_arready) state_d = S_R;
      end
      S_R: begin
        if (axi_rvalid) begin
          rdata_d = read_align(axi_rdata, addr_q[2:0], size_q);
          err_d   = (axi_rresp != 2'b00);
          state_d = S_DONE;
        end
      end
      S_AW_W: begin
        // AW and W complete in either order; B is only awaited once both have.
        aw_done_d = aw_done_q | axi_awready;
        w_done_d  = w_done_q | axi_wready;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        if (axi_bvalid) begin
          err_d   = (axi_bresp != 2'b00);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Every output below comes from a register or a state decode only.
  assign axi_arvalid = (state_q == S_AR);
  assign axi_araddr  = addr_q;
  assign axi_arid    = ID_W'(AXI_ID);
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = {1'b0, size_q};
  assign axi_arburst = 2'b01;
  assign axi_rready  = (state_q == S_R);

  assign axi_awvalid = (state_q == S_AW_W) && !aw_done_q;
  assign axi_awaddr  = addr_q;
  assign axi_awid    = ID_W'(AXI_ID);
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = {1'b0, size_q};
  assign axi_awburst = 2'b01;
  assign axi_wvalid  = (state_q == S_AW_W) && !w_done_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = 1'b1;
  assign axi_bready  = (state_q == S_B);

  assign rw_ready = (state_q == S_DONE);
  assign rw_rdata = rdata_q;
  assign rw_err   = err_q && (state_q == S_DONE);

endmodule
